median9_filter: RTL and testbench



---
 rtl/median9_filter.sv | 91 +++++++++
 tb/tb_median9_filter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/median9_filter.sv
// Three-stage pipelined median-of-nine selector for unsigned samples.
// Stage 1 sorts three groups of three, stage 2 reduces to lo/md/hi, stage 3 takes their median.
module median9_filter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a1,
    input  logic [DATA_WIDTH-1:0] a2,
    input  logic [DATA_WIDTH-1:0] a3,
    input  logic [DATA_WIDTH-1:0] a4,
    input  logic [DATA_WIDTH-1:0] a5,
    input  logic [DATA_WIDTH-1:0] a6,
    input  logic [DATA_WIDTH-1:0] a7,
    input  logic [DATA_WIDTH-1:0] a8,
    input  logic [DATA_WIDTH-1:0] a9,
    output logic [DATA_WIDTH-1:0] mid
);

    typedef logic [DATA_WIDTH-1:0] word_t;

    function automatic word_t max2(input word_t x, input word_t y);
        return (x > y) ? x : y;
    endfunction

    function automatic word_t min2(input word_t x, input word_t y);
        return (x < y) ? x : y;
    endfunction

    function automatic word_t max3(input word_t x, input word_t y, input word_t z);
        return max2(max2(x, y), z);
    endfunction

    function automatic word_t min3(input word_t x, input word_t y, input word_t z);
        return min2(min2(x, y), z);
    endfunction

    // Tie-safe: equal operands collapse through min/max to the same value.
    function automatic word_t med3(input word_t x, input word_t y, input word_t z);
        return max2(min2(x, y), min2(max2(x, y), z));
    endfunction

    word_t s1_max [3];
    word_t s1_med [3];
    word_t s1_min [3];
    word_t s2_lo, s2_md, s2_hi;

    word_t grp [3][3];

    always_comb begin
        grp[0][0] = a1; grp[0][1] = a2; grp[0][2] = a3;
        grp[1][0] = a4; grp[1][1] = a5; grp[1][2] = a6;
        grp[2][0] = a7; grp[2][1] = a8; grp[2][2] = a9;
    end

    // NOTE: pipeline state uses non-blocking assignments so every stage samples
    // the previous stage's pre-edge value; blocking here would collapse stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 3; g++) begin
                s1_max[g] <= '0;
                s1_med[g] <= '0;
                s1_min[g] <= '0;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                s1_max[g] <= max3(grp[g][0], grp[g][1], grp[g][2]);
                s1_med[g] <= med3(grp[g][0], grp[g][1], grp[g][2]);
                s1_min[g] <= min3(grp[g][0], grp[g][1], grp[g][2]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_lo <= '0;
            s2_md <= '0;
            s2_hi <= '0;
        end else begin
            s2_lo <= max3(s1_min[0], s1_min[1], s1_min[2]);
            s2_md <= med3(s1_med[0], s1_med[1], s1_med[2]);
            s2_hi <= min3(s1_max[0], s1_max[1], s1_max[2]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mid <= '0;
        else        mid <= med3(s2_lo, s2_md, s2_hi);
    end

endmodule

// File: tb/tb_median9_filter.sv
// Directed and randomized checks of median9_filter against a sort-based median model
// tracked at three-edge latency.
module tb_median9_filter;

    localparam int W = 64;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic         clk;
    logic         rst_n;
    logic [W-1:0] cur [9];
    logic [W-1:0] mid;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected medians of the inputs sampled at the last three edges.
    logic [W-1:0] hist [3];
    int           edges_since_rst;

    median9_filter #(.DATA_WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a1   (cur[0]),
        .a2   (cur[1]),
        .a3   (cur[2]),
        .a4   (cur[3]),
        .a5   (cur[4]),
        .a6   (cur[5]),
        .a7   (cur[6]),
        .a8   (cur[7]),
        .a9   (cur[8]),
        .mid  (mid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_median();
        logic [W-1:0] t [9];
        logic [W-1:0] tmp;
        for (int i = 0; i < 9; i++) t[i] = cur[i];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (t[j] > t[j+1]) begin
                    tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp;
                end
        return t[4];
    endfunction

    task automatic set_vals(input logic [W-1:0] v0, v1, v2, v3, v4, v5, v6, v7, v8);
        cur[0] = v0; cur[1] = v1; cur[2] = v2; cur[3] = v3; cur[4] = v4;
        cur[5] = v5; cur[6] = v6; cur[7] = v7; cur[8] = v8;
    endtask

    // One rising edge, then compare mid with the model one time unit later.
    task automatic tick(input string tag);
        logic [W-1:0] exp;
        @(posedge clk);
        #1;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = ref_median();
        edges_since_rst++;
        exp = (edges_since_rst >= 3) ? hist[2] : '0;
        check(tag, mid, exp);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        set_vals(0, 0, 0, 0, 0, 0, 0, 0, 0);
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        edges_since_rst = 0;

        #2;
        check("reset_mid_zero", mid, '0);
        #10;
        rst_n = 1'b1;
        edges_since_rst = 0;

        // Reference vector: 0,0 then 5 from the third edge.
        set_vals(5, 2, 3, 4, 1, 6, 7, 15, 9);
        tick("ref_edge1");
        tick("ref_edge2");
        tick("ref_edge3");
        check("ref_value5", mid, 64'd5);
        ticks("ref_hold", 2);

        // Asynchronous reset between edges while mid is 5.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clear", mid, '0);
        #1;
        rst_n = 1'b1;
        edges_since_rst = 0;
        tick("post_rst_edge1");
        tick("post_rst_edge2");
        tick("post_rst_edge3");
        check("post_rst_value5", mid, 64'd5);

        // Back-to-back sets: expect 5, 5, 7 on consecutive cycles.
        set_vals(1, 2, 3, 4, 5, 6, 7, 8, 9);
        tick("b2b_load_asc");
        set_vals(9, 8, 7, 6, 5, 4, 3, 2, 1);
        tick("b2b_load_desc");
        set_vals(7, 7, 7, 7, ALL1, 7, 7, 7, 7);
        tick("b2b_out_asc");
        check("b2b_asc_5", mid, 64'd5);
        tick("b2b_out_desc");
        check("b2b_desc_5", mid, 64'd5);
        tick("b2b_out_sevens");
        check("b2b_sevens_7", mid, 64'd7);

        // Ties and extremes.
        set_vals(ALL1, ALL1, ALL1, ALL1, ALL1, ALL1, ALL1, ALL1, ALL1);
        ticks("all_ones", 3);
        check("all_ones_val", mid, ALL1);
        set_vals(0, 0, 0, 0, 1, 1, 1, 1, 1);
        ticks("four_zeros", 3);
        check("four_zeros_val", mid, 64'd1);
        set_vals(0, 0, 0, 0, 0, 1, 1, 1, 1);
        ticks("five_zeros", 3);
        check("five_zeros_val", mid, 64'd0);
        set_vals(ALL1, 0, 64'h8000_0000_0000_0000, 1, ALL1, 64'h7FFF_FFFF_FFFF_FFFF,
                 0, 64'h8000_0000_0000_0001, 2);
        ticks("msb_mix", 3);
        check("msb_mix_val", mid, 64'h7FFF_FFFF_FFFF_FFFF);

        // Random sets, each followed by a random permutation of itself.
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 9; i++)
                cur[i] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3))
                                                     : {$urandom, $urandom};
            tick("rand_set");
            for (int i = 8; i > 0; i--) begin
                int j;
                logic [W-1:0] tmp;
                j = $urandom_range(0, i);
                tmp = cur[i]; cur[i] = cur[j]; cur[j] = tmp;
            end
            tick("rand_perm");
        end
        ticks("rand_drain", 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
